// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing one buffered FU result per cycle onto the
// registered common data bus; each FU owns a one-entry holding buffer.
module cdb_arbiter #(
  parameter int NUM_FU    = 5,
  parameter int RS_TAG_W  = 3,
  parameter int ROB_TAG_W = 3,
  parameter int XLEN      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU*RS_TAG_W-1:0]    fu_rs_tag,
  input  logic [NUM_FU*ROB_TAG_W-1:0]   fu_rob_tag,
  input  logic [NUM_FU*XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]             fu_ready,
  output logic                          cdb_valid,
  output logic [RS_TAG_W-1:0]           cdb_rs_tag,
  output logic [ROB_TAG_W-1:0]          cdb_rob_tag,
  output logic [XLEN-1:0]               cdb_value,
  output logic [NUM_FU-1:0]             cdb_grant
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0]    buf_valid_q, buf_valid_d;
  logic [RS_TAG_W-1:0]  buf_rs_tag_q  [NUM_FU];
  logic [RS_TAG_W-1:0]  buf_rs_tag_d  [NUM_FU];
  logic [ROB_TAG_W-1:0] buf_rob_tag_q [NUM_FU];
  logic [ROB_TAG_W-1:0] buf_rob_tag_d [NUM_FU];
  logic [XLEN-1:0]      buf_value_q   [NUM_FU];
  logic [XLEN-1:0]      buf_value_d   [NUM_FU];
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic                 cdb_valid_q, cdb_valid_d;
  logic [RS_TAG_W-1:0]  cdb_rs_tag_q, cdb_rs_tag_d;
  logic [ROB_TAG_W-1:0] cdb_rob_tag_q, cdb_rob_tag_d;
  logic [XLEN-1:0]      cdb_value_q, cdb_value_d;
  logic [NUM_FU-1:0]    cdb_grant_q, cdb_grant_d;

  logic [NUM_FU-1:0]    grant;
  logic [NUM_FU-1:0]    accept;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;

  // Two passes emulate a circular search: indices at/after rr_ptr first, then the wrap.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (!win_found && buf_valid_q[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (!win_found && buf_valid_q[i] && (PTR_W'(i) < rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    if (flush) begin
      win_found = 1'b0;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      grant[i] = win_found && (win_idx == PTR_W'(i));
    end
  end

  always_comb begin
    fu_ready = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = !flush && (!buf_valid_q[i] || grant[i]);
    end
    accept = fu_valid & fu_ready;
  end

  always_comb begin
    buf_valid_d   = buf_valid_q;
    buf_rs_tag_d  = buf_rs_tag_q;
    buf_rob_tag_d = buf_rob_tag_q;
    buf_value_d   = buf_value_q;
    cdb_valid_d   = 1'b0;
    cdb_rs_tag_d  = '1;
    cdb_rob_tag_d = '0;
    cdb_value_d   = '0;
    cdb_grant_d   = '0;
    rr_ptr_d      = rr_ptr_q;

    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        cdb_valid_d   = 1'b1;
        cdb_rs_tag_d  = buf_rs_tag_q[i];
        cdb_rob_tag_d = buf_rob_tag_q[i];
        cdb_value_d   = buf_value_q[i];
        buf_valid_d[i] = 1'b0;
      end
      // A granted buffer may refill at the same edge it drains.
      if (accept[i]) begin
        buf_valid_d[i]   = 1'b1;
        buf_rs_tag_d[i]  = fu_rs_tag[i*RS_TAG_W +: RS_TAG_W];
        buf_rob_tag_d[i] = fu_rob_tag[i*ROB_TAG_W +: ROB_TAG_W];
        buf_value_d[i]   = fu_value[i*XLEN +: XLEN];
      end
    end

    if (win_found) begin
      cdb_grant_d = grant;
      rr_ptr_d    = (win_idx == PTR_W'(NUM_FU - 1)) ? '0 : win_idx + 1'b1;
    end

    if (flush) begin
      buf_valid_d = '0;
      rr_ptr_d    = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid_q   <= '0;
      rr_ptr_q      <= '0;
      cdb_valid_q   <= 1'b0;
      cdb_rs_tag_q  <= '1;
      cdb_rob_tag_q <= '0;
      cdb_value_q   <= '0;
      cdb_grant_q   <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_rs_tag_q[i]  <= '1;
        buf_rob_tag_q[i] <= '0;
        buf_value_q[i]   <= '0;
      end
    end else begin
      buf_valid_q   <= buf_valid_d;
      rr_ptr_q      <= rr_ptr_d;
      cdb_valid_q   <= cdb_valid_d;
      cdb_rs_tag_q  <= cdb_rs_tag_d;
      cdb_rob_tag_q <= cdb_rob_tag_d;
      cdb_value_q   <= cdb_value_d;
      cdb_grant_q   <= cdb_grant_d;
      for (int i = 0; i < NUM_FU; i++) begin
        buf_rs_tag_q[i]  <= buf_rs_tag_d[i];
        buf_rob_tag_q[i] <= buf_rob_tag_d[i];
        buf_value_q[i]   <= buf_value_d[i];
      end
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rs_tag  = cdb_rs_tag_q;
  assign cdb_rob_tag = cdb_rob_tag_q;
  assign cdb_value   = cdb_value_q;
  assign cdb_grant   = cdb_grant_q;

endmodule
